// File: rtl/hockey_pkg.sv
// Shared types for the air-hockey engine: FSM states, puck direction,
// TURN/WINNER codes and the wall-bounce helper.
package hockey_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DISP    = 4'd1,
        SERVE_A = 4'd2,
        SERVE_B = 4'd3,
        MOVE_AB = 4'd4,
        MOVE_BA = 4'd5,
        RESP_A  = 4'd6,
        RESP_B  = 4'd7,
        GOAL_A  = 4'd8,
        GOAL_B  = 4'd9,
        WIN     = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'd0,
        DIR_UP       = 2'd1,
        DIR_DOWN     = 2'd2
    } dir_t;

    localparam logic [1:0] TURN_A      = 2'd0;
    localparam logic [1:0] TURN_B      = 2'd1;
    localparam logic [1:0] TURN_NONE   = 2'd2;

    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_A    = 2'd1;
    localparam logic [1:0] WINNER_B   = 2'd2;

    typedef struct packed {
        logic [31:0] y;
        dir_t        dir;
    } bounce_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Raw code 3 has no meaning of its own and plays as straight.
    function automatic dir_t decode_dir(input logic [1:0] raw);
        case (raw)
            2'd1:    return DIR_UP;
            2'd2:    return DIR_DOWN;
            default: return DIR_STRAIGHT;
        endcase
    endfunction

    // One vertical step; hitting the top or bottom wall reflects the puck.
    function automatic bounce_t bounce(input logic [31:0] y, input dir_t dir,
                                       input logic [31:0] court_y);
        bounce_t r;
        r.y   = y;
        r.dir = dir;
        case (dir)
            DIR_UP: begin
                if (y == court_y - 1) begin
                    r.y   = court_y - 2;
                    r.dir = DIR_DOWN;
                end else begin
                    r.y = y + 1;
                end
            end
            DIR_DOWN: begin
                if (y == 0) begin
                    r.y   = 1;
                    r.dir = DIR_UP;
                end else begin
                    r.y = y - 1;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hockey_tick_timer.sv
// Shared cycle timer: counts 0..limit, flags the terminal count and wraps,
// or is held at zero by clear.
module hockey_tick_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [TW-1:0] limit,
    output logic          done
);

    logic [TW-1:0] count;

    assign done = (count == limit);

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || done) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/hockey_court.sv
// Two-player air-hockey engine: serve/receive/goal sequencing, puck motion
// with wall bounce, and saturating scores.
module hockey_court
    import hockey_pkg::*;
#(
    parameter int COURT_X    = 5,
    parameter int COURT_Y    = 5,
    parameter int WIN_SCORE  = 3,
    parameter int STEP_TICKS = 3,
    parameter int RESP_TICKS = 3,
    parameter int DISP_TICKS = 3,
    parameter int GOAL_TICKS = 3,
    localparam int XW = $clog2(COURT_X),
    localparam int YW = $clog2(COURT_Y),
    localparam int SW = $clog2(WIN_SCORE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          BTNA,
    input  logic          BTNB,
    input  logic [1:0]    DIRA,
    input  logic [1:0]    DIRB,
    input  logic [YW-1:0] YA,
    input  logic [YW-1:0] YB,
    output logic [XW-1:0] X_COORD,
    output logic [YW-1:0] Y_COORD,
    output logic [SW-1:0] SCORE_A,
    output logic [SW-1:0] SCORE_B,
    output logic [1:0]    TURN,
    output logic [3:0]    STATE,
    output logic [1:0]    WINNER
);

    localparam int TMAX = max2(max2(STEP_TICKS, RESP_TICKS), max2(DISP_TICKS, GOAL_TICKS));
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_t        state;
    dir_t          dir;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [SW-1:0] score_a;
    logic [SW-1:0] score_b;
    logic [1:0]    turn;
    logic [1:0]    winner;

    logic          t_done;
    logic          t_clear;
    logic [TW-1:0] t_limit;
    logic          hit_a;
    logic          hit_b;
    logic          ya_ok;
    logic          yb_ok;
    bounce_t       nb;

    assign X_COORD = x;
    assign Y_COORD = y;
    assign SCORE_A = score_a;
    assign SCORE_B = score_b;
    assign TURN    = turn;
    assign STATE   = state;
    assign WINNER  = winner;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        t_limit = '0;
        hit_a   = (state == RESP_A) && BTNA && (YA == y);
        hit_b   = (state == RESP_B) && BTNB && (YB == y);
        ya_ok   = 32'(YA) < 32'(COURT_Y);
        yb_ok   = 32'(YB) < 32'(COURT_Y);
        nb      = bounce(32'(y), dir, 32'(COURT_Y));
        case (state)
            DISP:             t_limit = TW'(DISP_TICKS - 1);
            MOVE_AB, MOVE_BA: t_limit = TW'(STEP_TICKS - 1);
            RESP_A, RESP_B:   t_limit = TW'(RESP_TICKS - 1);
            GOAL_A, GOAL_B:   t_limit = TW'(GOAL_TICKS - 1);
            default:          t_limit = '0;
        endcase
        // Timer idles at zero outside timed states; a hit restarts it for the return.
        t_clear = (state == IDLE) || (state == SERVE_A) || (state == SERVE_B) ||
                  (state == WIN) || hit_a || hit_b;
    end

    hockey_tick_timer #(
        .TW (TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst),
        .clear (t_clear),
        .limit (t_limit),
        .done  (t_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            dir     <= DIR_STRAIGHT;
            x       <= '0;
            y       <= '0;
            score_a <= '0;
            score_b <= '0;
            turn    <= TURN_NONE;
            winner  <= WINNER_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (BTNA && !BTNB) begin
                        turn  <= TURN_A;
                        state <= DISP;
                    end else if (BTNB && !BTNA) begin
                        turn  <= TURN_B;
                        state <= DISP;
                    end
                end
                DISP: begin
                    if (t_done) state <= (turn == TURN_A) ? SERVE_A : SERVE_B;
                end
                SERVE_A: begin
                    if (BTNA && ya_ok) begin
                        x     <= '0;
                        y     <= YA;
                        dir   <= decode_dir(DIRA);
                        state <= MOVE_AB;
                    end
                end
                SERVE_B: begin
                    if (BTNB && yb_ok) begin
                        x     <= XW'(COURT_X - 1);
                        y     <= YB;
                        dir   <= decode_dir(DIRB);
                        state <= MOVE_BA;
                    end
                end
                MOVE_AB: begin
                    if (t_done) begin
                        x   <= x + XW'(1);
                        y   <= YW'(nb.y);
                        dir <= nb.dir;
                        if (x == XW'(COURT_X - 2)) state <= RESP_B;
                    end
                end
                MOVE_BA: begin
                    if (t_done) begin
                        x   <= x - XW'(1);
                        y   <= YW'(nb.y);
                        dir <= nb.dir;
                        if (x == XW'(1)) state <= RESP_A;
                    end
                end
                RESP_B: begin
                    if (hit_b) begin
                        x     <= XW'(COURT_X - 2);
                        dir   <= decode_dir(DIRB);
                        state <= MOVE_BA;
                    end else if (t_done) begin
                        if (score_a != SW'(WIN_SCORE)) score_a <= score_a + SW'(1);
                        state <= GOAL_A;
                    end
                end
                RESP_A: begin
                    if (hit_a) begin
                        x     <= XW'(1);
                        dir   <= decode_dir(DIRA);
                        state <= MOVE_AB;
                    end else if (t_done) begin
                        if (score_b != SW'(WIN_SCORE)) score_b <= score_b + SW'(1);
                        state <= GOAL_B;
                    end
                end
                GOAL_A: begin
                    if (t_done) begin
                        if (score_a == SW'(WIN_SCORE)) begin
                            winner <= WINNER_A;
                            state  <= WIN;
                        end else begin
                            turn  <= TURN_B;
                            state <= SERVE_B;
                        end
                    end
                end
                GOAL_B: begin
                    if (t_done) begin
                        if (score_b == SW'(WIN_SCORE)) begin
                            winner <= WINNER_B;
                            state  <= WIN;
                        end else begin
                            turn  <= TURN_A;
                            state <= SERVE_A;
                        end
                    end
                end
                WIN:     ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hockey_court.sv
// Directed bench for hockey_court at default parameters: serve, bounce,
// hit, miss, goal hold, async reset mid-play and the win condition.
module tb_hockey_court;
    import hockey_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       BTNA = 1'b0;
    logic       BTNB = 1'b0;
    logic [1:0] DIRA = 2'd0;
    logic [1:0] DIRB = 2'd0;
    logic [2:0] YA = 3'd0;
    logic [2:0] YB = 3'd0;
    logic [2:0] X_COORD;
    logic [2:0] Y_COORD;
    logic [1:0] SCORE_A;
    logic [1:0] SCORE_B;
    logic [1:0] TURN;
    logic [3:0] STATE;
    logic [1:0] WINNER;

    int checks = 0;
    int errors = 0;

    hockey_court dut (
        .clk     (clk),
        .rst     (rst),
        .BTNA    (BTNA),
        .BTNB    (BTNB),
        .DIRA    (DIRA),
        .DIRB    (DIRB),
        .YA      (YA),
        .YB      (YB),
        .X_COORD (X_COORD),
        .Y_COORD (Y_COORD),
        .SCORE_A (SCORE_A),
        .SCORE_B (SCORE_B),
        .TURN    (TURN),
        .STATE   (STATE),
        .WINNER  (WINNER)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] target, input int budget);
        int n = 0;
        while (STATE !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(STATE), 32'(target));
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, 32'(X_COORD), ex);
        check({tag, "_y"}, 32'(Y_COORD), ey);
    endtask

    initial begin
        tick(2);
        check("rst_state", 32'(STATE), 32'(IDLE));
        check_pos("rst", 0, 0);
        check("rst_sa", 32'(SCORE_A), 0);
        check("rst_sb", 32'(SCORE_B), 0);
        check("rst_turn", 32'(TURN), 2);
        check("rst_winner", 32'(WINNER), 0);
        rst = 1'b1;
        tick(1);

        // Both buttons together must not start a game.
        BTNA = 1'b1; BTNB = 1'b1;
        tick(1);
        check("both_idle", 32'(STATE), 32'(IDLE));
        check("both_turn", 32'(TURN), 2);
        BTNA = 1'b0; BTNB = 1'b0;

        BTNA = 1'b1;
        tick(1);
        BTNA = 1'b0;
        check("disp_enter", 32'(STATE), 32'(DISP));
        check("disp_turn", 32'(TURN), 0);
        tick(2);
        check("disp_hold", 32'(STATE), 32'(DISP));
        tick(1);
        check("serve_a", 32'(STATE), 32'(SERVE_A));

        // Serve up from row 2: rows 2,3,4,3,2 across columns 0..4.
        YA = 3'd2; DIRA = 2'd1; BTNA = 1'b1;
        tick(1);
        BTNA = 1'b0;
        check("move_ab", 32'(STATE), 32'(MOVE_AB));
        check_pos("serve", 0, 2);
        tick(2); check_pos("pre_step1", 0, 2);
        tick(1); check_pos("step1", 1, 3);
        tick(3); check_pos("step2", 2, 4);
        tick(3); check_pos("step3", 3, 3);
        tick(2);
        check_pos("pre_step4", 3, 3);
        check("pre_arrive", 32'(STATE), 32'(MOVE_AB));
        tick(1);
        check_pos("arrive", 4, 2);
        check("resp_b", 32'(STATE), 32'(RESP_B));

        // B hits in window cycle 1.
        tick(1);
        check("resp_b_c1", 32'(STATE), 32'(RESP_B));
        YB = 3'd2; DIRB = 2'd0; BTNB = 1'b1;
        tick(1);
        BTNB = 1'b0;
        check("hit_b_state", 32'(STATE), 32'(MOVE_BA));
        check_pos("hit_b", 3, 2);
        check("hit_b_score", 32'(SCORE_A), 0);

        tick(8);
        check_pos("ba_mid", 1, 2);
        tick(1);
        check("resp_a", 32'(STATE), 32'(RESP_A));
        check_pos("arrive_a", 0, 2);

        // A returns downward in window cycle 0; bounces off the bottom wall.
        BTNA = 1'b1; YA = 3'd2; DIRA = 2'd2;
        tick(1);
        BTNA = 1'b0;
        check("hit_a_state", 32'(STATE), 32'(MOVE_AB));
        check_pos("hit_a", 1, 2);
        tick(3); check_pos("down1", 2, 1);
        tick(3); check_pos("down2", 3, 0);
        tick(3); check_pos("bounce", 4, 1);
        check("resp_b2", 32'(STATE), 32'(RESP_B));

        // B presses on the wrong row for the whole window: goal for A.
        BTNB = 1'b1; YB = 3'd3;
        tick(2);
        check("miss_hold", 32'(STATE), 32'(RESP_B));
        check("miss_hold_sa", 32'(SCORE_A), 0);
        tick(1);
        BTNB = 1'b0;
        check("goal_a", 32'(STATE), 32'(GOAL_A));
        check("goal_a_sa", 32'(SCORE_A), 1);
        tick(2);
        check("goal_a_hold", 32'(STATE), 32'(GOAL_A));
        tick(1);
        check("serve_b", 32'(STATE), 32'(SERVE_B));
        check("serve_b_turn", 32'(TURN), 1);

        // Out-of-range row is ignored; then a serve with direction code 3.
        YB = 3'd5; BTNB = 1'b1;
        tick(1);
        check("serve_b_oob", 32'(STATE), 32'(SERVE_B));
        YB = 3'd1; DIRB = 2'd3;
        tick(1);
        BTNB = 1'b0;
        check("move_ba", 32'(STATE), 32'(MOVE_BA));
        check_pos("serve_b", 4, 1);
        tick(4);
        check_pos("ba_step", 3, 1);

        // Asynchronous reset mid-step.
        rst = 1'b0;
        #1;
        check("arst_state", 32'(STATE), 32'(IDLE));
        check_pos("arst", 0, 0);
        check("arst_sa", 32'(SCORE_A), 0);
        check("arst_turn", 32'(TURN), 2);
        check("arst_winner", 32'(WINNER), 0);
        @(negedge clk);
        rst = 1'b1;
        tick(1);

        BTNB = 1'b1;
        tick(1);
        BTNB = 1'b0;
        check("resume_disp", 32'(STATE), 32'(DISP));
        check("resume_turn", 32'(TURN), 1);
        wait_state("resume_serve", SERVE_B, 10);

        // Three rallies, each lost by B.
        for (int i = 0; i < 3; i++) begin
            YB = 3'd0; DIRB = 2'd0; BTNB = 1'b1;
            tick(1);
            BTNB = 1'b0;
            wait_state("rally_resp_a", RESP_A, 20);
            BTNA = 1'b1; YA = 3'd0; DIRA = 2'd0;
            tick(1);
            BTNA = 1'b0;
            check_pos("rally_hit", 1, 0);
            wait_state("rally_resp_b", RESP_B, 20);
            wait_state("rally_goal", GOAL_A, 10);
            check("rally_score", 32'(SCORE_A), i + 1);
            if (i < 2) wait_state("rally_serve", SERVE_B, 10);
            else wait_state("win", WIN, 10);
        end
        check("win_winner", 32'(WINNER), 1);

        // Terminal state ignores all inputs.
        for (int i = 0; i < 6; i++) begin
            BTNA = i[0]; BTNB = i[1]; YA = 3'(i); YB = 3'(i); DIRA = 2'(i); DIRB = 2'(i);
            tick(1);
        end
        BTNA = 1'b0; BTNB = 1'b0;
        check("win_state", 32'(STATE), 32'(WIN));
        check("win_frozen_winner", 32'(WINNER), 1);
        check("win_sa", 32'(SCORE_A), 3);
        check("win_sb", 32'(SCORE_B), 0);
        check("win_turn", 32'(TURN), 1);
        check_pos("win", 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
